// File: rtl/debounce_toggle_bank.sv
// Bank of independent debounced switch channels with press/release/long-press pulses
// and a per-channel toggle latch that flips on either the press or the release edge.
module debounce_toggle_bank #(
  parameter int                NUM_CH          = 4,
  parameter int                DEBOUNCE_LIMIT  = 250000,
  parameter int                LONG_LIMIT      = 12500000,
  parameter logic [NUM_CH-1:0] TOGGLE_ON_PRESS = '0
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic [NUM_CH-1:0] i_Toggle_Clr,
  output logic [NUM_CH-1:0] o_State,
  output logic [NUM_CH-1:0] o_Press,
  output logic [NUM_CH-1:0] o_Release,
  output logic [NUM_CH-1:0] o_Long,
  output logic [NUM_CH-1:0] o_Toggle
);

  localparam int DW = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int LW = $clog2(LONG_LIMIT + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_LIMIT - 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_LIMIT);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_LIMIT - 1);

  logic [NUM_CH-1:0] sync1_q, sync1_d;
  logic [NUM_CH-1:0] sync2_q, sync2_d;
  logic [NUM_CH-1:0] state_q, state_d;
  logic [NUM_CH-1:0] press_q, press_d;
  logic [NUM_CH-1:0] rel_q, rel_d;
  logic [NUM_CH-1:0] long_q, long_d;
  logic [NUM_CH-1:0] toggle_q, toggle_d;
  logic [DW-1:0]     deb_cnt_q  [NUM_CH];
  logic [DW-1:0]     deb_cnt_d  [NUM_CH];
  logic [LW-1:0]     long_cnt_q [NUM_CH];
  logic [LW-1:0]     long_cnt_d [NUM_CH];

  always_comb begin
    sync1_d  = i_Switch;
    sync2_d  = sync1_q;
    state_d  = state_q;
    press_d  = '0;
    rel_d    = '0;
    long_d   = '0;
    toggle_d = toggle_q;
    for (int i = 0; i < NUM_CH; i++) begin
      deb_cnt_d[i]  = '0;
      long_cnt_d[i] = '0;

      if (sync2_q[i] != state_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          state_d[i] = sync2_q[i];
          press_d[i] = sync2_q[i];
          rel_d[i]   = ~sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end

      // Counting on the next level makes the counter equal the number of held cycles,
      // so the pulse lands in the cycle the count first reaches LONG_LIMIT.
      if (state_d[i]) begin
        long_cnt_d[i] = (long_cnt_q[i] == LONG_MAX) ? LONG_MAX : long_cnt_q[i] + 1'b1;
        long_d[i]     = (long_cnt_q[i] == LONG_LAST);
      end

      if (i_Toggle_Clr[i]) begin
        toggle_d[i] = 1'b0;
      end else if (TOGGLE_ON_PRESS[i] ? press_q[i] : rel_q[i]) begin
        toggle_d[i] = ~toggle_q[i];
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      state_q  <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      long_q   <= '0;
      toggle_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        deb_cnt_q[i]  <= '0;
        long_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      state_q  <= state_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      long_q   <= long_d;
      toggle_q <= toggle_d;
      for (int i = 0; i < NUM_CH; i++) begin
        deb_cnt_q[i]  <= deb_cnt_d[i];
        long_cnt_q[i] <= long_cnt_d[i];
      end
    end
  end

  assign o_State   = state_q;
  assign o_Press   = press_q;
  assign o_Release = rel_q;
  assign o_Long    = long_q;
  assign o_Toggle  = toggle_q;

endmodule

// File: tb/tb_debounce_toggle_bank.sv
// Directed bench for debounce_toggle_bank: two channels, short debounce/long limits.
module tb_debounce_toggle_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sw;
  logic [1:0] clr;
  logic [1:0] st, prs, rls, lng, tgl;

  int n_checks = 0;
  int n_fail   = 0;

  debounce_toggle_bank #(
    .NUM_CH         (2),
    .DEBOUNCE_LIMIT (4),
    .LONG_LIMIT     (10),
    .TOGGLE_ON_PRESS(2'b10)
  ) dut (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .i_Switch    (sw),
    .i_Toggle_Clr(clr),
    .o_State     (st),
    .o_Press     (prs),
    .o_Release   (rls),
    .o_Long      (lng),
    .o_Toggle    (tgl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n clock edges; sample and drive 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    sw  = 2'b11;
    clr = 2'b00;

    // 1: reset with both switches held, then simultaneous debounce on both channels
    tick(3);
    chk("rst_state", st, 2'b00);
    chk("rst_press", prs, 2'b00);
    chk("rst_rel", rls, 2'b00);
    chk("rst_long", lng, 2'b00);
    chk("rst_tgl", tgl, 2'b00);
    rst = 1'b0;
    tick(5);
    chk("rst_state_5", st, 2'b00);
    chk("rst_press_5", prs, 2'b00);
    tick(1);
    chk("rst_state_6", st, 2'b11);
    chk("rst_press_6", prs, 2'b11);
    chk("rst_rel_6", rls, 2'b00);
    tick(1);
    chk("rst_press_7", prs, 2'b00);
    chk("tgl_on_press", tgl, 2'b10);
    tick(7);
    chk("long_c9", lng, 2'b00);
    tick(1);
    chk("long_c10", lng, 2'b11);
    tick(1);
    chk("long_c11", lng, 2'b00);

    // 3: release both; ch0 toggles on release, ch1 does not
    sw = 2'b00;
    tick(5);
    chk("rel_state_5", st, 2'b11);
    tick(1);
    chk("rel_state_6", st, 2'b00);
    chk("rel_pulse", rls, 2'b11);
    chk("rel_press", prs, 2'b00);
    tick(1);
    chk("rel_pulse_end", rls, 2'b00);
    chk("tgl_on_rel", tgl, 2'b11);

    // 2: bounce on ch0 (1 x3, 0 x1, then held)
    sw = 2'b01;
    tick(3);
    sw = 2'b00;
    tick(1);
    sw = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      chk("bnc_no_press", prs, 2'b00);
      chk("bnc_state_lo", st, 2'b00);
    end
    tick(1);
    chk("bnc_state_hi", st, 2'b01);
    chk("bnc_press", prs, 2'b01);
    tick(1);
    chk("bnc_press_end", prs, 2'b00);
    chk("tgl_ch0_no_press", tgl, 2'b11);

    // 4: long press, one pulse on the 10th held cycle
    for (int k = 3; k <= 20; k++) begin
      tick(1);
      chk("long_hold", lng, (k == 10) ? 2'b01 : 2'b00);
    end
    sw = 2'b00;
    tick(6);
    chk("long_rel_state", st, 2'b00);
    chk("long_rel_pulse", rls, 2'b01);
    tick(1);
    chk("long_rel_tgl", tgl, 2'b10);

    // 4b: 9-cycle press produces no long pulse
    sw = 2'b01;
    tick(6);
    chk("short_state", st, 2'b01);
    chk("short_press", prs, 2'b01);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("short_no_long", lng, 2'b00);
    end
    sw = 2'b00;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("short_no_long", lng, 2'b00);
    end
    tick(1);
    chk("short_rel_state", st, 2'b00);
    chk("short_rel_pulse", rls, 2'b01);
    chk("short_no_long", lng, 2'b00);
    tick(1);
    chk("short_tgl", tgl, 2'b11);

    // 5: clear alone, then clear colliding with a release toggle
    clr = 2'b01;
    tick(1);
    chk("clr_only", tgl, 2'b10);
    clr = 2'b00;
    sw  = 2'b01;
    tick(6);
    chk("clr_press", st, 2'b01);
    sw = 2'b00;
    tick(6);
    chk("clr_rel_pulse", rls, 2'b01);
    chk("clr_tgl_before", tgl, 2'b10);
    clr = 2'b01;
    tick(1);
    chk("clr_priority", tgl, 2'b10);
    clr = 2'b00;

    // 6: reset while ch0 held, then fresh press with no release
    sw = 2'b01;
    tick(6);
    chk("mid_state", st, 2'b01);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_state", st, 2'b00);
    chk("mid_rst_rel", rls, 2'b00);
    chk("mid_rst_press", prs, 2'b00);
    chk("mid_rst_tgl", tgl, 2'b00);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      chk("mid_no_rel", rls, 2'b00);
      chk("mid_state_lo", st, 2'b00);
    end
    tick(1);
    chk("mid_repress_state", st, 2'b01);
    chk("mid_repress_pulse", prs, 2'b01);
    chk("mid_repress_rel", rls, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
